countdown_share_ctrl: RTL and testbench

- Controller that shares one WIDTH-bit down counter between two requesters.
- Each requester supplies a countdown load value. The block arbitrates round-robin, loads the winner's value, and counts down to zero while honouring a global pause. It then returns a one-cycle done pulse to the owner.
- Sits between requesting FSMs and the down-counter datapath; exports the live count for debug.

---
 rtl/countdown_share_ctrl.sv | 158 +++++++++++++++
 tb/tb_countdown_share_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_share_ctrl.sv
// countdown_share_ctrl
//
// Shares one WIDTH-bit down counter between two requesters. The block
// arbitrates round-robin, loads the winner's value and counts down to zero.
// A global pause freezes the count. A one-cycle done pulse then goes back
// to the owner. Every output is driven straight from a flop.
//
// Build option:
//   COUNTDOWN_SHARE_ABORT_EN - when defined, the countdown is aborted if the
//   owner drops its request while counting. The count value is frozen, no
//   done pulse is issued, and the owner becomes "last". When the macro is
//   undefined, a request that drops after the grant is ignored.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate between req0/req1 on each edge
// ST_COUNT | owner holds the counter; decrement unless paused
// ST_DONE  | one cycle: done pulse to owner, gnt still high, cnt = 0

module countdown_share_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  input  logic             pause,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  // Identity of the most recent owner; 1 out of reset so req0 wins the first tie.
  logic             last_q, last_d;

  // Current owner index. The grants are one-hot outside IDLE, so gnt1 alone identifies the owner.
  logic             owner;
  // On a tie, grant requester 1 only when requester 0 was the last owner.
  logic             pick1;
`ifdef COUNTDOWN_SHARE_ABORT_EN
  logic             owner_req;
`endif

  assign owner = gnt1_q;
  assign pick1 = req1 && (!req0 || (last_q == 1'b0));
`ifdef COUNTDOWN_SHARE_ABORT_EN
  assign owner_req = owner ? req1 : req0;
`endif

  // State register and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: arbitration, countdown, done handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          cnt_d   = pick1 ? val1 : val0;
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
`ifdef COUNTDOWN_SHARE_ABORT_EN
        // An abort takes precedence over both pause and terminal count.
        if (!owner_req) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          last_d  = owner;
          state_d = ST_IDLE;
        end else
`endif
        if (pause) begin
          cnt_d = cnt_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          done0_d = !owner;
          done1_d = owner;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        cnt_d   = '0;
        last_d  = owner;
        state_d = ST_IDLE;
      end

      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_countdown_share_ctrl.sv
// Directed bench for countdown_share_ctrl (WIDTH = 5). Edges are numbered
// from the first rising edge after reset release. Outputs are sampled 1 time
// unit after the edge.
module tb_countdown_share_ctrl;

  logic       clk;
  logic       rst;
  logic       req0, req1, pause;
  logic [4:0] val0, val1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [4:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  countdown_share_ctrl #(.WIDTH(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .val0  (val0),
    .val1  (val1),
    .pause (pause),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .cnt   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_g0, input logic e_g1,
                            input logic e_d0, input logic e_d1, input logic e_busy,
                            input logic [4:0] e_cnt);
    chk_bit({tag, ".gnt0"}, gnt0, e_g0);
    chk_bit({tag, ".gnt1"}, gnt1, e_g1);
    chk_bit({tag, ".done0"}, done0, e_d0);
    chk_bit({tag, ".done1"}, done1, e_d1);
    chk_bit({tag, ".busy"}, busy, e_busy);
    chk_cnt({tag, ".cnt"}, cnt, e_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    pause = 1'b0;
    #2;
    expect_out("rst_async", 0, 0, 0, 0, 0, 5'd0);
    step();
    rst = 1'b0;
  endtask

  // Invariants checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      assert (!(gnt0 && gnt1)) else begin
        n_errors++;
        $error("FAIL gnt_onehot: observed gnt0=%b gnt1=%b expected not both", gnt0, gnt1);
      end
      n_checks++;
      assert (!(done0 && !gnt0) && !(done1 && !gnt1)) else begin
        n_errors++;
        $error("FAIL done_needs_gnt: observed done0=%b gnt0=%b done1=%b gnt1=%b", done0, gnt0, done1, gnt1);
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; pause = 1'b0; val0 = '0; val1 = '0;
    #12;
    expect_out("reset", 0, 0, 0, 0, 0, 5'd0);
    step();
    rst = 1'b0;

    // Single requester with load value 5.
    req0 = 1'b1; val0 = 5'd5;
    step(); expect_out("t1_grant", 1, 0, 0, 0, 1, 5'd5);
    for (int i = 4; i >= 0; i--) begin
      step(); expect_out("t1_count", 1, 0, 0, 0, 1, 5'(i));
    end
    step(); expect_out("t1_done", 1, 0, 1, 0, 1, 5'd0);
    req0 = 1'b0;
    step(); expect_out("t1_release", 0, 0, 0, 0, 0, 5'd0);
    step(); expect_out("t1_idle", 0, 0, 0, 0, 0, 5'd0);

    // Both requesting from reset: req0 first, then req1, then req0 again.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; val0 = 5'd3; val1 = 5'd2;
    step(); expect_out("t2_grant0", 1, 0, 0, 0, 1, 5'd3);
    for (int i = 2; i >= 0; i--) begin
      step(); expect_out("t2_count0", 1, 0, 0, 0, 1, 5'(i));
    end
    step(); expect_out("t2_done0", 1, 0, 1, 0, 1, 5'd0);
    step(); expect_out("t2_gap", 0, 0, 0, 0, 0, 5'd0);
    step(); expect_out("t2_grant1", 0, 1, 0, 0, 1, 5'd2);
    step(); expect_out("t2_count1a", 0, 1, 0, 0, 1, 5'd1);
    step(); expect_out("t2_count1b", 0, 1, 0, 0, 1, 5'd0);
    step(); expect_out("t2_done1", 0, 1, 0, 1, 1, 5'd0);
    req1 = 1'b0;
    step(); expect_out("t2_gap2", 0, 0, 0, 0, 0, 5'd0);
    step(); expect_out("t2_regrant0", 1, 0, 0, 0, 1, 5'd3);

    // Pause for three cycles at cnt=2 delays done1 by three edges.
    do_reset();
    req1 = 1'b1; val1 = 5'd4;
    step(); expect_out("t3_grant", 0, 1, 0, 0, 1, 5'd4);
    step(); expect_out("t3_c3", 0, 1, 0, 0, 1, 5'd3);
    step(); expect_out("t3_c2", 0, 1, 0, 0, 1, 5'd2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("t3_paused", 0, 1, 0, 0, 1, 5'd2);
    end
    pause = 1'b0;
    step(); expect_out("t3_c1", 0, 1, 0, 0, 1, 5'd1);
    step(); expect_out("t3_c0", 0, 1, 0, 0, 1, 5'd0);
    step(); expect_out("t3_done1", 0, 1, 0, 1, 1, 5'd0);
    req1 = 1'b0; pause = 1'b1;
    step(); expect_out("t3_done_ignores_pause", 0, 0, 0, 0, 0, 5'd0);

    // Load value 0 while pause is high in IDLE: grant still happens, done 1 edge later.
    req0 = 1'b1; val0 = 5'd0;
    step(); expect_out("t4_grant", 1, 0, 0, 0, 1, 5'd0);
    pause = 1'b0;
    step(); expect_out("t4_done0", 1, 0, 1, 0, 1, 5'd0);
    req0 = 1'b0;
    step(); expect_out("t4_idle", 0, 0, 0, 0, 0, 5'd0);

    // Full-scale load; changing val0 after the grant must not matter.
    req0 = 1'b1; val0 = 5'd31;
    step(); expect_out("t5_grant", 1, 0, 0, 0, 1, 5'd31);
    val0 = 5'd7;
    for (int i = 30; i >= 0; i--) begin
      step(); expect_out("t5_count", 1, 0, 0, 0, 1, 5'(i));
    end
    step(); expect_out("t5_done0", 1, 0, 1, 0, 1, 5'd0);
    req0 = 1'b0;
    step(); expect_out("t5_idle", 0, 0, 0, 0, 0, 5'd0);

    // Owner drops req at cnt=6.
    req0 = 1'b1; val0 = 5'd8;
    step(); expect_out("t6_grant", 1, 0, 0, 0, 1, 5'd8);
    step(); expect_out("t6_c7", 1, 0, 0, 0, 1, 5'd7);
    step(); expect_out("t6_c6", 1, 0, 0, 0, 1, 5'd6);
    req0 = 1'b0;
`ifdef COUNTDOWN_SHARE_ABORT_EN
    step(); expect_out("t6_abort", 0, 0, 0, 0, 0, 5'd6);
    step(); expect_out("t6_abort_hold", 0, 0, 0, 0, 0, 5'd6);
`else
    for (int i = 5; i >= 0; i--) begin
      step(); expect_out("t6_ignore_drop", 1, 0, 0, 0, 1, 5'(i));
    end
    step(); expect_out("t6_done0", 1, 0, 1, 0, 1, 5'd0);
    step(); expect_out("t6_idle", 0, 0, 0, 0, 0, 5'd0);
`endif

    // Asynchronous reset at cnt=9: immediate clear, no done.
    req0 = 1'b1; val0 = 5'd15;
    step(); expect_out("t7_grant", 1, 0, 0, 0, 1, 5'd15);
    for (int i = 14; i >= 9; i--) begin
      step(); expect_out("t7_count", 1, 0, 0, 0, 1, 5'(i));
    end
    #2 rst = 1'b1;
    #1 expect_out("t7_async_rst", 0, 0, 0, 0, 0, 5'd0);
    step(); expect_out("t7_held_rst", 0, 0, 0, 0, 0, 5'd0);
    req0 = 1'b0;
    rst = 1'b0;
    step(); expect_out("t7_after_rst", 0, 0, 0, 0, 0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
